// File: rtl/dt_pkg.sv
// Shared types and sizes for the distance-transform result-RAM arbiter.
package dt_pkg;

  localparam int AW = 14;
  localparam int DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic owner_t;

  localparam owner_t OWNER_M0 = 1'b0;
  localparam owner_t OWNER_M1 = 1'b1;

endpackage

// File: rtl/dt_arb_pick.sv
// Combinational winner select used when the arbiter leaves IDLE.
// DT_ARB_RR_EN defined: a tie goes to the requester that did not own last; otherwise m0 wins ties.
module dt_arb_pick (
  input  logic   i_req0,
  input  logic   i_req1,
  input  logic   i_last_owner,
  output logic   o_any,
  output logic   o_win
);
  import dt_pkg::*;

`ifndef DT_ARB_RR_EN
  logic w_unused_last;
  assign w_unused_last = i_last_owner;
`endif

  always_comb begin
    o_any = i_req0 | i_req1;
    o_win = OWNER_M0;
    if (i_req0 && i_req1) begin
`ifdef DT_ARB_RR_EN
      o_win = ~i_last_owner;
`else
      o_win = OWNER_M0;
`endif
    end else if (i_req1) begin
      o_win = OWNER_M1;
    end
  end

endmodule

// File: rtl/dt_res_arbiter.sv
// Two-requester arbiter for the single-port distance-transform result RAM, with hold limit and lock.
// Optional build macro DT_ARB_RR_EN selects round-robin tie-breaking from IDLE (default: m0 priority).
module dt_res_arbiter #(
  parameter int AW       = dt_pkg::AW,
  parameter int DW       = dt_pkg::DW,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_do,
  input  logic [DW-1:0] mem_di
);
  import dt_pkg::*;

  localparam int            HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t    r_state, w_state_nxt;
  logic [HW-1:0] r_hold_cnt, w_hold_nxt;
  owner_t        r_last_owner, w_last_nxt;
  logic          r_vld_p1;
  owner_t        r_owner_p1;
  logic          w_pick_any;
  owner_t        w_pick_win;
  logic          w_gnt_any;
  logic          w_other_req;

  dt_arb_pick u_pick (
    .i_req0       (m0_req),
    .i_req1       (m1_req),
    .i_last_owner (r_last_owner),
    .o_any        (w_pick_any),
    .o_win        (w_pick_win)
  );

  // Stage p0: grant and RAM access in the same cycle
  always_comb begin
    m0_gnt   = (r_state == OWN0) && m0_req;
    m1_gnt   = (r_state == OWN1) && m1_req;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_do   = '0;
    if (m0_gnt) begin
      mem_rd   = ~m0_we;
      mem_wr   = m0_we;
      mem_addr = m0_addr;
      mem_do   = m0_we ? m0_wdata : '0;
    end else if (m1_gnt) begin
      mem_rd   = ~m1_we;
      mem_wr   = m1_we;
      mem_addr = m1_addr;
      mem_do   = m1_we ? m1_wdata : '0;
    end
  end

  assign w_gnt_any   = m0_gnt | m1_gnt;
  assign w_other_req = (r_state == OWN0) ? m1_req : m0_req;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_last_nxt  = r_last_owner;
    case (r_state)
      IDLE: begin
        if (w_pick_any) w_state_nxt = (w_pick_win == OWNER_M1) ? OWN1 : OWN0;
      end
      OWN0: begin
        if (!m0_req)                                         w_state_nxt = m1_req ? OWN1 : IDLE;
        else if (m1_req && !m0_lock && r_hold_cnt == HOLD_LAST) w_state_nxt = OWN1;
      end
      OWN1: begin
        if (!m1_req)                                         w_state_nxt = m0_req ? OWN0 : IDLE;
        else if (m0_req && !m1_lock && r_hold_cnt == HOLD_LAST) w_state_nxt = OWN0;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Counter only runs while the other side is actually waiting, and parks at the limit under lock
    if (w_state_nxt != r_state || w_state_nxt == IDLE)
      w_hold_nxt = '0;
    else if (w_gnt_any && w_other_req && r_hold_cnt != HOLD_LAST)
      w_hold_nxt = r_hold_cnt + 1'b1;

    if (w_state_nxt == OWN0 && r_state != OWN0) w_last_nxt = OWNER_M0;
    if (w_state_nxt == OWN1 && r_state != OWN1) w_last_nxt = OWNER_M1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hold_cnt   <= '0;
      r_last_owner <= OWNER_M1;
      r_vld_p1     <= 1'b0;
      r_owner_p1   <= OWNER_M0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_last_owner <= w_last_nxt;
      r_vld_p1     <= mem_rd;
      r_owner_p1   <= m1_gnt ? OWNER_M1 : OWNER_M0;
    end
  end

  // Stage p1: RAM read data returned to the requester that issued the read
  always_comb begin
    m0_rvalid = r_vld_p1 && (r_owner_p1 == OWNER_M0);
    m1_rvalid = r_vld_p1 && (r_owner_p1 == OWNER_M1);
    m0_rdata  = m0_rvalid ? mem_di : '0;
    m1_rdata  = m1_rvalid ? mem_di : '0;
  end

endmodule

// File: tb/tb_dt_res_arbiter.sv
// Self-checking bench for dt_res_arbiter: directed sequences plus a read-data scoreboard.
module tb_dt_res_arbiter;

  localparam int AW       = 14;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_do, mem_di;

  always #5 clk = ~clk;

  dt_res_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_do(mem_do), .mem_di(mem_di)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 32'h81) return 8'h05;
    return 8'(a * 7 + 3);
  endfunction

  // RAM model: strobes captured mid-cycle, applied at the next rising edge
  logic [DW-1:0] ram [int];
  logic          lat_rd, lat_wr;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_do;

  initial begin
    mem_di = '0;
    forever begin
      @(negedge clk);
      lat_rd = mem_rd; lat_wr = mem_wr; lat_addr = mem_addr; lat_do = mem_do;
      @(posedge clk);
      if (lat_wr) ram[int'(lat_addr)] = lat_do;
      if (lat_rd) mem_di = ram.exists(int'(lat_addr)) ? ram[int'(lat_addr)] : init_val(int'(lat_addr));
    end
  end

  // Scoreboard: expected read data pushed at grant, popped at rvalid
  typedef struct {
    logic          own;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb_q [$];
  logic [DW-1:0] ref_mem [int];

  task automatic mon_port(input logic own, input logic gnt, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic rv, input logic [DW-1:0] rd);
    sb_t e;
    if (rv) begin
      if (sb_q.size() == 0) begin
        chk("sb_underrun", 32'(sb_q.size()), 1);
      end else begin
        e = sb_q.pop_front();
        chk("rv_owner", 32'(own), 32'(e.own));
        chk("rdata", 32'(rd), 32'(e.data));
      end
    end
    if (gnt) begin
      chk("mem_addr", 32'(mem_addr), 32'(addr));
      chk("mem_rd", 32'(mem_rd), 32'(!we));
      chk("mem_wr", 32'(mem_wr), 32'(we));
      if (we) begin
        chk("mem_do", 32'(mem_do), 32'(wd));
        ref_mem[int'(addr)] = wd;
      end else begin
        e.own  = own;
        e.data = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : init_val(int'(addr));
        sb_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      chk("gnt_onehot", 32'(m0_gnt & m1_gnt), 0);
      chk("rd_wr_excl", 32'(mem_rd & mem_wr), 0);
      mon_port(1'b0, m0_gnt, m0_we, m0_addr, m0_wdata, m0_rvalid, m0_rdata);
      mon_port(1'b1, m1_gnt, m1_we, m1_addr, m1_wdata, m1_rvalid, m1_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // m0 streams writes, m1 waits on a read; lock is held for the first lock_cyc cycles
  task automatic hold_run(input string tag, input int lock_cyc);
    int   last;
    int   wi;
    logic g0;
    last = (lock_cyc > MAX_HOLD - 1) ? lock_cyc : MAX_HOLD - 1;
    wi   = 0;
    step();
    m0_req = 1'b1; m0_we = 1'b1; m0_lock = (lock_cyc > 0);
    m0_addr = 14'h0100; m0_wdata = 8'hA0;
    mid();
    step();
    mid();
    chk({tag, "_first_gnt0"}, 32'(m0_gnt), 1);
    step();
    wi = 1;
    m0_addr = AW'(32'h100 + wi); m0_wdata = DW'(32'hA0 + wi);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h0100;
    for (int c = 0; c <= last + 1; c++) begin
      mid();
      g0 = m0_gnt;
      chk({tag, "_gnt0"}, 32'(m0_gnt), 32'(c <= last));
      chk({tag, "_gnt1"}, 32'(m1_gnt), 32'(c == last + 1));
      step();
      if (g0) begin
        wi++;
        m0_addr = AW'(32'h100 + wi); m0_wdata = DW'(32'hA0 + wi);
      end
      m0_lock = (c + 1 < lock_cyc);
      if (c == last + 1) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end
    end
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
    step(); step(); mid();
    chk("rst_gnt0", 32'(m0_gnt), 0);
    chk("rst_gnt1", 32'(m1_gnt), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_do", 32'(mem_do), 0);
    chk("rst_rvalid0", 32'(m0_rvalid), 0);
    chk("rst_rvalid1", 32'(m1_rvalid), 0);
    chk("rst_rdata0", 32'(m0_rdata), 0);
    step();
    reset = 1'b0;

    // single m0 read from IDLE, then withdraw to IDLE
    step();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0081;
    mid();
    chk("t1_lat_gnt0", 32'(m0_gnt), 0);
    step(); mid();
    chk("t1_gnt0", 32'(m0_gnt), 1);
    chk("t1_mem_rd", 32'(mem_rd), 1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h81);
    step();
    m0_req = 1'b0;
    mid();
    chk("t1_rvalid0", 32'(m0_rvalid), 1);
    chk("t1_rdata0", 32'(m0_rdata), 32'h05);
    chk("t5_gnt0", 32'(m0_gnt), 0);
    chk("t5_mem_rd", 32'(mem_rd), 0);
    chk("t5_mem_wr", 32'(mem_wr), 0);
    step(); mid();
    chk("t5_idle_rd", 32'(mem_rd), 0);
    chk("t5_idle_rvalid0", 32'(m0_rvalid), 0);

    // tie from IDLE with last owner m0
    step();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0010;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h0020;
    mid();
    chk("t2_lat_gnt", 32'(m0_gnt | m1_gnt), 0);
    step(); mid();
`ifdef DT_ARB_RR_EN
    chk("t2_gnt0", 32'(m0_gnt), 0);
    chk("t2_gnt1", 32'(m1_gnt), 1);
`else
    chk("t2_gnt0", 32'(m0_gnt), 1);
    chk("t2_gnt1", 32'(m1_gnt), 0);
`endif
    step();
    m0_req = 1'b0; m1_req = 1'b0;
    step(); step();

    hold_run("t3", 0);
    hold_run("t4", 7);

    // reset while an m1 read is in flight
    step();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h0020;
    mid();
    chk("t6_lat_gnt1", 32'(m1_gnt), 0);
    step(); mid();
    chk("t6_gnt1", 32'(m1_gnt), 1);
    chk("t6_mem_rd", 32'(mem_rd), 1);
    step();
    reset = 1'b1; m1_req = 1'b0;
    #1;
    chk("t6_rst_rvalid1", 32'(m1_rvalid), 0);
    chk("t6_rst_rdata1", 32'(m1_rdata), 0);
    chk("t6_rst_mem_rd", 32'(mem_rd), 0);
    chk("t6_rst_mem_wr", 32'(mem_wr), 0);
    chk("t6_rst_gnt1", 32'(m1_gnt), 0);
    step(); step();
    reset = 1'b0;
    step();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0030;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h0040;
    mid();
    chk("t6_post_lat", 32'(m0_gnt | m1_gnt), 0);
    step(); mid();
    chk("t6_post_gnt0", 32'(m0_gnt), 1);
    chk("t6_post_gnt1", 32'(m1_gnt), 0);
    step();
    m0_req = 1'b0; m1_req = 1'b0;
    step(); step(); mid();
    chk("sb_drain", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
